// File: rtl/vram_arbiter_if.sv
// Bus bundle for vram_arbiter: VGA read port, keyboard write port and the
// character-RAM port. slave = arbiter side, master = the surrounding logic.
interface vram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int LVL_W  = 3
);
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic              o_rd_valid;
    logic [DATA_W-1:0] o_rd_data;
    logic              i_wr_valid;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ready;
    logic [LVL_W-1:0]  o_fifo_level;
    logic              o_ram_en;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] i_ram_rdata;

    modport slave (
        input  i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
        output o_rd_valid, o_rd_data, o_wr_ready, o_fifo_level,
               o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
    );

    modport master (
        output i_rd_req, i_rd_addr, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
        input  o_rd_valid, o_rd_data, o_wr_ready, o_fifo_level,
               o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port character RAM arbiter: VGA reads take every slot they ask for,
// keyboard writes queue in a small FIFO and drain into otherwise idle slots.
module vram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    vram_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} slot_t;

    logic [ADDR_W+DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              wr_ready_q, wr_ready_d;
    slot_t             state_q, state_d;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              rd_stage_q, rd_stage_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              push, pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    assign {head_addr, head_data} = fifo_mem_q[rd_ptr_q];

    always_comb begin
        push = bus.i_wr_valid && wr_ready_q;
        // Popping uses the registered level, so a fresh push waits one cycle.
        pop  = !bus.i_rd_req && (level_q != '0);

        if (bus.i_rd_req)  state_d = S_READ;
        else if (pop)      state_d = S_WRITE;
        else               state_d = S_IDLE;

        ram_en_d    = (state_d != S_IDLE);
        ram_we_d    = (state_d == S_WRITE);
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (state_d == S_READ) begin
            ram_addr_d = bus.i_rd_addr;
        end else if (state_d == S_WRITE) begin
            ram_addr_d  = head_addr;
            ram_wdata_d = head_data;
        end

        // state_q == S_READ means a read strobe is on the RAM port this cycle.
        rd_stage_d = (state_q == S_READ);
        rd_valid_d = rd_stage_q;
        rd_data_d  = rd_stage_q ? bus.i_ram_rdata : rd_data_q;

        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
        wr_ready_d = (level_d < LVL_W'(FIFO_DEPTH));
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {bus.i_wr_addr, bus.i_wr_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            wr_ready_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_stage_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            wr_ready_q  <= wr_ready_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_stage_q  <= rd_stage_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign bus.o_rd_valid   = rd_valid_q;
    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_wr_ready   = wr_ready_q;
    assign bus.o_fifo_level = level_q;
    assign bus.o_ram_en     = ram_en_q;
    assign bus.o_ram_we     = ram_we_q;
    assign bus.o_ram_addr   = ram_addr_q;
    assign bus.o_ram_wdata  = ram_wdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for single-slot behaviour plus
// hand sequences for streaming reads, priority/full, hazard and mid-op reset.
module tb_vram_arbiter;
    localparam int AW = 12, DW = 8, DEPTH = 4, LW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LVL_W(LW)) bus ();
    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst), .bus(bus)
    );

    typedef struct packed {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          valid;
        logic [DW-1:0] rd;
        logic          ready;
        logic [LW-1:0] lvl;
    } outs_t;

    typedef struct {
        logic          rd;
        logic [AW-1:0] ra;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        outs_t         exp;
    } vec_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    wr_t wlog[$];

    // Behavioural RAM: registered read; untouched cells return a fixed pattern.
    logic [DW-1:0] ram [int];
    logic [DW-1:0] rdata_q = '0;
    assign bus.i_ram_rdata = rdata_q;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    always @(posedge clk) begin : ram_model
        int a;
        wr_t e;
        cyc <= cyc + 1;
        a = int'(bus.o_ram_addr);
        if (bus.o_ram_en) begin
            if (bus.o_ram_we) begin
                ram[a] = bus.o_ram_wdata;
                e.cyc = cyc; e.a = bus.o_ram_addr; e.d = bus.o_ram_wdata;
                wlog.push_back(e);
            end else begin
                rdata_q <= ram.exists(a) ? ram[a] : init_val(bus.o_ram_addr);
            end
        end
    end

    function automatic outs_t mk(logic en, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                                 logic valid, logic [DW-1:0] rd, logic ready, logic [LW-1:0] lvl);
        outs_t o;
        o.en = en; o.we = we; o.addr = addr; o.wd = wd;
        o.valid = valid; o.rd = rd; o.ready = ready; o.lvl = lvl;
        return o;
    endfunction

    function automatic outs_t snap();
        return mk(bus.o_ram_en, bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata,
                  bus.o_rd_valid, bus.o_rd_data, bus.o_wr_ready, bus.o_fifo_level);
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("[TB] ok %s = %h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic rd, logic [AW-1:0] ra, logic wv, logic [AW-1:0] wa, logic [DW-1:0] wd);
        bus.i_rd_req = rd; bus.i_rd_addr = ra;
        bus.i_wr_valid = wv; bus.i_wr_addr = wa; bus.i_wr_data = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[8];
        int   nxt, maxlvl, gaps;
        logic rdy, wv, any_valid;

        tbl[0] = '{1'b0, 12'h000, 1'b1, 12'h005, 8'h41, mk(0, 0, 12'h000, 8'h00, 0, 8'h00, 1, 3'd1)};
        tbl[1] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, mk(1, 1, 12'h005, 8'h41, 0, 8'h00, 1, 3'd0)};
        tbl[2] = '{1'b1, 12'h005, 1'b0, 12'h000, 8'h00, mk(1, 0, 12'h005, 8'h41, 0, 8'h00, 1, 3'd0)};
        tbl[3] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, mk(0, 0, 12'h005, 8'h41, 0, 8'h00, 1, 3'd0)};
        tbl[4] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, mk(0, 0, 12'h005, 8'h41, 1, 8'h41, 1, 3'd0)};
        tbl[5] = '{1'b1, 12'h005, 1'b1, 12'h007, 8'h55, mk(1, 0, 12'h005, 8'h41, 0, 8'h41, 1, 3'd1)};
        tbl[6] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, mk(1, 1, 12'h007, 8'h55, 0, 8'h41, 1, 3'd0)};
        tbl[7] = '{1'b0, 12'h000, 1'b0, 12'h000, 8'h00, mk(0, 0, 12'h007, 8'h55, 1, 8'h41, 1, 3'd0)};

        // Reset held three cycles, then release.
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outputs", 64'(snap()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        step();
        chk("after_release", 64'(snap()), 64'(mk(0, 0, 0, 0, 0, 0, 1, 0)));

        // Idle-bus write, read-back, and read-beats-write in the same cycle.
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].rd, tbl[i].ra, tbl[i].wv, tbl[i].wa, tbl[i].wd);
            step();
            chk($sformatf("vec%0d", i), 64'(snap()), 64'(tbl[i].exp));
        end

        // Eight back-to-back reads: one valid per cycle, three cycles after each request.
        for (int c = 0; c < 14; c++) begin
            logic          ev;
            logic [DW-1:0] ed;
            drive(c < 8, 12'(12'h100 + c), 0, 0, 0);
            step();
            ev = (c >= 2 && c < 10);
            ed = ev ? init_val(12'(12'h100 + c - 2)) : 8'h00;
            chk($sformatf("b2b_c%0d", c), {55'd0, bus.o_rd_valid, bus.o_rd_valid ? bus.o_rd_data : 8'h00},
                {55'd0, ev, ed});
        end

        // Hazard: reads of a still-queued address return the old contents.
        drive(1, 12'h030, 1, 12'h030, 8'h77); step();
        drive(1, 12'h030, 0, 0, 0);           step();
        drive(0, 0, 0, 0, 0);                 step();
        chk("hazard_rd1", {55'd0, bus.o_rd_valid, bus.o_rd_data}, {55'd0, 1'b1, init_val(12'h030)});
        step();
        chk("hazard_rd2", {55'd0, bus.o_rd_valid, bus.o_rd_data}, {55'd0, 1'b1, init_val(12'h030)});
        drive(1, 12'h030, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0);       step(); step();
        chk("hazard_rd3", {55'd0, bus.o_rd_valid, bus.o_rd_data}, {55'd0, 1'b1, 8'h77});

        // Reader holds the bus 20 cycles while six writes are offered.
        repeat (3) step();
        wlog.delete();
        nxt = 0;
        for (int c = 0; c < 20; c++) begin
            wv  = (nxt < 6);
            rdy = bus.o_wr_ready;
            drive(1, 0, wv, 12'(12'h010 + nxt), 8'(8'h60 + nxt));
            step();
            if (wv && rdy) nxt++;
        end
        chk("prio_accepted", 64'(nxt), 64'd4);
        chk("prio_ready", 64'(bus.o_wr_ready), 64'd0);
        chk("prio_level", 64'(bus.o_fifo_level), 64'd4);
        chk("prio_no_we", 64'(wlog.size()), 64'd0);
        drive(0, 0, 0, 0, 0);
        repeat (10) step();
        chk("drain_count", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("drain_w%0d", i), {44'd0, wlog[i].a, wlog[i].d},
                    {44'd0, 12'(12'h010 + i), 8'(8'h60 + i)});
                chk($sformatf("drain_t%0d", i), 64'(wlog[i].cyc - wlog[0].cyc), 64'(i));
            end
        end

        // Fill to four, then stream twelve writes through a draining FIFO.
        wlog.delete();
        nxt = 0;
        maxlvl = 0;
        for (int c = 0; c < 40; c++) begin
            wv  = (nxt < 12);
            rdy = bus.o_wr_ready;
            drive(c < 6, 0, wv, 12'(12'h020 + nxt), 8'(8'h90 + nxt));
            step();
            if (wv && rdy) nxt++;
            if (int'(bus.o_fifo_level) > maxlvl) maxlvl = int'(bus.o_fifo_level);
            if (c == 5) chk("stream_full_level", 64'(bus.o_fifo_level), 64'd4);
        end
        drive(0, 0, 0, 0, 0);
        chk("stream_max_level", 64'(maxlvl), 64'd4);
        chk("stream_count", 64'(wlog.size()), 64'd12);
        if (wlog.size() == 12) begin
            gaps = 0;
            for (int i = 0; i < 12; i++) begin
                chk($sformatf("stream_w%0d", i), {44'd0, wlog[i].a, wlog[i].d},
                    {44'd0, 12'(12'h020 + i), 8'(8'h90 + i)});
                if (i > 0 && wlog[i].cyc - wlog[i-1].cyc != 1) gaps++;
            end
            chk("stream_gaps", 64'(gaps), 64'd0);
        end

        // Reset with three reads in flight and two writes queued.
        repeat (3) step();
        wlog.delete();
        drive(1, 12'h100, 1, 12'h040, 8'h88); step();
        drive(1, 12'h101, 1, 12'h041, 8'h89); step();
        chk("midrst_level_before", 64'(bus.o_fifo_level), 64'd2);
        drive(1, 12'h102, 0, 0, 0);
        rst = 1'b1;
        step();
        chk("midrst_outputs", 64'(snap()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        any_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            any_valid |= bus.o_rd_valid;
        end
        chk("midrst_no_valid", 64'(any_valid), 64'd0);
        chk("midrst_no_write", 64'(wlog.size()), 64'd0);
        chk("midrst_level", 64'(bus.o_fifo_level), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
